issue_queue_nway: RTL

Parametrised, age-ordered issue queue that succeeds the fixed 16-entry, 4-wide issue window between rename/dispatch and the function units. It accepts up to DISPATCH_W renamed instructions per cycle and wakes source operands from WAKE_W broadcast tags, with same-cycle bypass into incoming instructions. Each cycle it selects the two oldest ready entries for two issue ports with valid/ready handshakes. Freed entries are reclaimed in age order, and flush empties the queue.

---
 rtl/iq_pkg.sv | 27 ++
 rtl/iq_age_select.sv | 45 ++++
 rtl/issue_queue_nway.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// Shared types and constants for the n-way issue queue.
package iq_pkg;

  // Tag and payload widths fixed by the entry layout below.
  localparam int IQ_TAG_W = 6;
  localparam int IQ_PAY_W = 64;

  // Physical register 0 is hard-wired ready; a source naming it never waits.
  localparam logic [IQ_TAG_W-1:0] TAG_ZERO = '0;

  // One queue slot.
  typedef struct packed {
    logic                valid;
    logic                rdy1;
    logic                rdy2;
    logic [IQ_TAG_W-1:0] src1;
    logic [IQ_TAG_W-1:0] src2;
    logic [IQ_TAG_W-1:0] dst;
    logic [IQ_PAY_W-1:0] pay;
  } iq_entry_t;

  // Head/tail pointers carry one wrap bit above the slot index.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Finds the two oldest set bits of a candidate vector, oldest = first at or
// after head_idx going round the circular array.
module iq_age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]         cand,
  input  logic [$clog2(DEPTH)-1:0] head_idx,
  output logic [$clog2(DEPTH)-1:0] sel0_idx,
  output logic [$clog2(DEPTH)-1:0] sel1_idx,
  output logic                     sel0_found,
  output logic                     sel1_found
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [2*DEPTH-1:0] dbl;
  logic [DEPTH-1:0]   rot;
  logic [IDX_W-1:0]   off0;
  logic [IDX_W-1:0]   off1;

  // Rotate so bit 0 is the head slot, then take the first two set bits.
  always_comb begin
    dbl        = {cand, cand} >> head_idx;
    rot        = dbl[DEPTH-1:0];
    off0       = '0;
    off1       = '0;
    sel0_found = 1'b0;
    sel1_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rot[i]) begin
        if (!sel0_found) begin
          sel0_found = 1'b1;
          off0       = IDX_W'(i);
        end else if (!sel1_found) begin
          sel1_found = 1'b1;
          off1       = IDX_W'(i);
        end
      end
    end
    // DEPTH is a power of two, so the index add wraps naturally.
    sel0_idx = head_idx + off0;
    sel1_idx = head_idx + off1;
  end

endmodule

// File: rtl/issue_queue_nway.sv
// Age-ordered issue queue: multi-lane dispatch, tag wakeup with same-cycle
// bypass, two-port oldest-first select, in-order head reclaim, flush.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. iss_valid depends only on registered state and never waits on
// iss_ready; a port whose ready is low keeps presenting the same entry.
// disp_ready depends only on occupancy; a dispatch group is taken whole or
// not at all.
module issue_queue_nway
  import iq_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 4,
  parameter int WAKE_W     = 4,
  parameter int TAG_W      = IQ_TAG_W,
  parameter int PAY_W      = IQ_PAY_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [DISPATCH_W-1:0]   disp_valid,
  input  logic [DISPATCH_W*TAG_W-1:0] disp_src1,
  input  logic [DISPATCH_W*TAG_W-1:0] disp_src2,
  input  logic [DISPATCH_W*TAG_W-1:0] disp_dst,
  input  logic [DISPATCH_W-1:0]   disp_rdy1,
  input  logic [DISPATCH_W-1:0]   disp_rdy2,
  input  logic [DISPATCH_W*PAY_W-1:0] disp_pay,
  output logic                    disp_ready,
  input  logic [WAKE_W-1:0]       wk_valid,
  input  logic [WAKE_W*TAG_W-1:0] wk_tag,
  output logic [1:0]              iss_valid,
  input  logic [1:0]              iss_ready,
  output logic [2*TAG_W-1:0]      iss_dst,
  output logic [2*TAG_W-1:0]      iss_src1,
  output logic [2*TAG_W-1:0]      iss_src2,
  output logic [2*PAY_W-1:0]      iss_pay,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  iq_entry_t        ent_q [DEPTH];
  iq_entry_t        ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] occ, free_slots, wr_ptr, scan;
  logic [DEPTH-1:0] cand, res_hit1, res_hit2, alive;
  logic [DISPATCH_W-1:0] new_hit1, new_hit2;
  logic [IDX_W-1:0] sel0_idx, sel1_idx;
  logic             sel0_found, sel1_found;
  logic             disp_go;

  assign occ        = tail_q - head_q;
  assign free_slots = PTR_W'(DEPTH) - occ;
  assign disp_ready = (free_slots >= PTR_W'(DISPATCH_W));
  assign disp_go    = disp_ready & (|disp_valid);
  assign count      = occ;
  assign full       = (occ == PTR_W'(DEPTH));
  assign empty      = (occ == '0);

  // Wakeup compare for resident entries, plus candidate vector for select.
  for (genvar i = 0; i < DEPTH; i++) begin : g_res
    logic [WAKE_W-1:0] m1, m2;
    for (genvar k = 0; k < WAKE_W; k++) begin : g_port
      assign m1[k] = wk_valid[k] & (wk_tag[k*TAG_W +: TAG_W] == ent_q[i].src1);
      assign m2[k] = wk_valid[k] & (wk_tag[k*TAG_W +: TAG_W] == ent_q[i].src2);
    end
    assign res_hit1[i] = |m1;
    assign res_hit2[i] = |m2;
    assign cand[i]     = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
  end

  // Wakeup compare for incoming lanes: the same-cycle bypass.
  for (genvar l = 0; l < DISPATCH_W; l++) begin : g_lane
    logic [WAKE_W-1:0] m1, m2;
    for (genvar k = 0; k < WAKE_W; k++) begin : g_port
      assign m1[k] = wk_valid[k] &
                     (wk_tag[k*TAG_W +: TAG_W] == disp_src1[l*TAG_W +: TAG_W]);
      assign m2[k] = wk_valid[k] &
                     (wk_tag[k*TAG_W +: TAG_W] == disp_src2[l*TAG_W +: TAG_W]);
    end
    assign new_hit1[l] = disp_rdy1[l] | (disp_src1[l*TAG_W +: TAG_W] == TAG_ZERO) | (|m1);
    assign new_hit2[l] = disp_rdy2[l] | (disp_src2[l*TAG_W +: TAG_W] == TAG_ZERO) | (|m2);
  end

  iq_age_select #(.DEPTH(DEPTH)) u_sel (
    .cand       (cand),
    .head_idx   (head_q[IDX_W-1:0]),
    .sel0_idx   (sel0_idx),
    .sel1_idx   (sel1_idx),
    .sel0_found (sel0_found),
    .sel1_found (sel1_found)
  );

  assign iss_valid = {sel1_found, sel0_found};

  // Issue ports read the selected entries straight from registers.
  always_comb begin
    iss_dst  = '0;
    iss_src1 = '0;
    iss_src2 = '0;
    iss_pay  = '0;
    if (sel0_found) begin
      iss_dst[TAG_W-1:0]  = ent_q[sel0_idx].dst;
      iss_src1[TAG_W-1:0] = ent_q[sel0_idx].src1;
      iss_src2[TAG_W-1:0] = ent_q[sel0_idx].src2;
      iss_pay[PAY_W-1:0]  = ent_q[sel0_idx].pay;
    end
    if (sel1_found) begin
      iss_dst[2*TAG_W-1:TAG_W]  = ent_q[sel1_idx].dst;
      iss_src1[2*TAG_W-1:TAG_W] = ent_q[sel1_idx].src1;
      iss_src2[2*TAG_W-1:TAG_W] = ent_q[sel1_idx].src2;
      iss_pay[2*PAY_W-1:PAY_W]  = ent_q[sel1_idx].pay;
    end
  end

  // Next state: wakeup accumulate, frees, head reclaim, dispatch, flush.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    wr_ptr = tail_q;
    scan   = '0;
    alive  = '0;

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i].rdy1 = ent_q[i].rdy1 | res_hit1[i];
      ent_d[i].rdy2 = ent_q[i].rdy2 | res_hit2[i];
    end

    if (iss_valid[0] & iss_ready[0]) ent_d[sel0_idx].valid = 1'b0;
    if (iss_valid[1] & iss_ready[1]) ent_d[sel1_idx].valid = 1'b0;

    // Head jumps to the oldest survivor; if none remain it meets the old tail,
    // which is where this cycle's dispatch (if any) lands.
    for (int i = 0; i < DEPTH; i++) alive[i] = ent_d[i].valid;
    head_d = tail_q;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan = head_q + PTR_W'(i);
      if ((PTR_W'(i) < occ) && alive[scan[IDX_W-1:0]]) head_d = scan;
    end

    if (disp_go) begin
      for (int l = 0; l < DISPATCH_W; l++) begin
        if (disp_valid[l]) begin
          ent_d[wr_ptr[IDX_W-1:0]].valid = 1'b1;
          ent_d[wr_ptr[IDX_W-1:0]].rdy1  = new_hit1[l];
          ent_d[wr_ptr[IDX_W-1:0]].rdy2  = new_hit2[l];
          ent_d[wr_ptr[IDX_W-1:0]].src1  = disp_src1[l*TAG_W +: TAG_W];
          ent_d[wr_ptr[IDX_W-1:0]].src2  = disp_src2[l*TAG_W +: TAG_W];
          ent_d[wr_ptr[IDX_W-1:0]].dst   = disp_dst[l*TAG_W +: TAG_W];
          ent_d[wr_ptr[IDX_W-1:0]].pay   = disp_pay[l*PAY_W +: PAY_W];
          wr_ptr = wr_ptr + PTR_ONE;
        end
      end
      tail_d = wr_ptr;
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      head_d = '0;
      tail_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ent_q  <= ent_d;
    end
  end

endmodule
